// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive path.
//   rx_state_e     receiver FSM states
//   UART_DATA_BITS payload bits per frame (8N1)
//   clks_per_bit   clock cycles per line bit for a given clock and baud rate
package uart_pkg;

    typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, STOP} rx_state_e;

    localparam int UART_DATA_BITS = 8;

    function automatic int clks_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous first-word-fall-through FIFO for received bytes.
//   clk_i, rst_i  clock, asynchronous active-high reset
//   push_i/data_i write request and byte; accepted if not full or popping this cycle
//   pop_i         read request; ignored when empty
//   data_o        head entry (0 when empty)
//   full_o/empty_o occupancy flags
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             do_pop, do_push;

    // Extra wrap bit distinguishes full from empty when the indices coincide.
    assign empty_o = wr_ptr == rd_ptr;
    assign full_o  = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = empty_o ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART receiver with a valid/ready byte stream output.
//   clk_i        clock (CLK_FREQ_HZ)
//   rst_i        asynchronous active-high reset; aborts any frame in progress
//   rx_i         asynchronous serial line, idle high
//   data_o       received byte, valid while valid_o=1
//   valid_o      byte available; transfer on valid_o && ready_i at posedge
//   ready_i      consumer accepts
//   frame_err_o  1-cycle pulse: stop bit sampled low, byte discarded
//   overrun_o    1-cycle pulse: completed byte dropped because the buffer was full
//   busy_o       frame reception in progress
// Build option: define UART_RX_FIFO_EN for a FIFO_DEPTH-entry output FIFO;
// otherwise a single holding register buffers one byte.
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 5_000_000,
    parameter int BAUD_RATE   = 115200,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      rx_i,
    output logic [UART_DATA_BITS-1:0] data_o,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic                      frame_err_o,
    output logic                      overrun_o,
    output logic                      busy_o
);

    localparam int CPB = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
    localparam int CW  = $clog2(CPB);
    localparam logic [CW-1:0] HALF_LAST = CW'(CPB / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2 and at least 2");
    end

    logic                      sync_q, rx_s;
    rx_state_e                 state;
    logic [CW-1:0]             cnt;
    logic [2:0]                bit_cnt;
    logic [UART_DATA_BITS-1:0] shift;
    logic                      tick, push, pop, full;

    // START waits half a bit so every later sample lands mid-bit.
    assign tick   = cnt == (state == START ? HALF_LAST : BIT_LAST);
    assign push   = state == STOP && tick && rx_s;
    assign pop    = valid_o && ready_i;
    assign busy_o = state inside {START, DATA, STOP};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q      <= 1'b1;
            rx_s        <= 1'b1;
            state       <= WAIT_IDLE;
            cnt         <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            sync_q      <= rx_i;
            rx_s        <= sync_q;
            frame_err_o <= state == STOP && tick && !rx_s;
            overrun_o   <= push && full && !pop;
            cnt         <= (busy_o && !tick) ? cnt + 1'b1 : '0;
            case (state)
                WAIT_IDLE: if (rx_s) state <= IDLE;
                IDLE:      if (!rx_s) state <= START;
                START: if (tick) begin
                    state   <= rx_s ? IDLE : DATA;
                    bit_cnt <= '0;
                end
                DATA: if (tick) begin
                    shift   <= {rx_s, shift[UART_DATA_BITS-1:1]};
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == 3'(UART_DATA_BITS - 1)) state <= STOP;
                end
                // A low stop bit may be a break; wait for the line to return high.
                STOP:    if (tick) state <= rx_s ? IDLE : WAIT_IDLE;
                default: state <= WAIT_IDLE;
            endcase
        end
    end

`ifdef UART_RX_FIFO_EN
    logic empty;

    uart_rx_fifo #(
        .WIDTH(UART_DATA_BITS),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push_i (push),
        .pop_i  (pop),
        .data_i (shift),
        .data_o (data_o),
        .full_o (full),
        .empty_o(empty)
    );

    assign valid_o = !empty;
`else
    assign full = valid_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            data_o  <= '0;
        end else if (push && (!full || pop)) begin
            valid_o <= 1'b1;
            data_o  <= shift;
        end else if (pop) begin
            valid_o <= 1'b0;
        end
    end
`endif

endmodule
